// File: rtl/regfile_pkg.sv
// Shared widths and the dump FSM state type for the register-file dump reader.
// CSUM exists only when REGFILE_DUMP_CHECKSUM_EN is defined.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 6;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EMIT = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } dump_state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EMIT = 3'd2,
        DONE = 3'd4
    } dump_state_t;
`endif

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Request, register-file read-port and output-beat signals of the dump reader.
// slave is the dump reader side, master is the requester / register-file side.
interface regfile_dump_reader_if;
    import regfile_pkg::*;

    logic                  start;
    logic [REG_ADDR_W-1:0] first_reg;
    logic [CNT_W-1:0]      count;
    logic [REG_ADDR_W-1:0] SA;
    logic [REG_ADDR_W-1:0] SB;
    logic [REG_DATA_W-1:0] A;
    logic [REG_DATA_W-1:0] B;
    logic [REG_DATA_W-1:0] out_data;
    logic [REG_ADDR_W-1:0] out_index;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport slave (
        input  start, first_reg, count, A, B, out_ready,
        output SA, SB, out_data, out_index, out_valid, out_last, busy, done
    );

    modport master (
        output start, first_reg, count, A, B, out_ready,
        input  SA, SB, out_data, out_index, out_valid, out_last, busy, done
    );

endinterface

// File: rtl/regfile_dump_buf.sv
// Two-entry capture buffer: loads both read ports at once, pops one entry per beat,
// exposes the head entry and the number of valid entries left.
module regfile_dump_buf
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [1:0]            i_load_n,
    input  logic [REG_DATA_W-1:0] i_data0,
    input  logic [REG_DATA_W-1:0] i_data1,
    input  logic [REG_ADDR_W-1:0] i_idx0,
    input  logic [REG_ADDR_W-1:0] i_idx1,
    input  logic                  i_pop,
    output logic [REG_DATA_W-1:0] o_head_data,
    output logic [REG_ADDR_W-1:0] o_head_index,
    output logic [1:0]            o_fill
);

    logic [REG_DATA_W-1:0] r_data0;
    logic [REG_DATA_W-1:0] r_data1;
    logic [REG_ADDR_W-1:0] r_idx0;
    logic [REG_ADDR_W-1:0] r_idx1;
    logic                  r_head;
    logic [1:0]            r_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_idx0  <= '0;
            r_idx1  <= '0;
            r_head  <= 1'b0;
            r_fill  <= 2'd0;
        end else if (i_load) begin
            r_data0 <= i_data0;
            r_data1 <= i_data1;
            r_idx0  <= i_idx0;
            r_idx1  <= i_idx1;
            r_head  <= 1'b0;
            r_fill  <= i_load_n;
        end else if (i_pop && (r_fill != 2'd0)) begin
            r_head  <= ~r_head;
            r_fill  <= r_fill - 2'd1;
        end
    end

    assign o_head_data  = r_head ? r_data1 : r_data0;
    assign o_head_index = r_head ? r_idx1  : r_idx0;
    assign o_fill       = r_fill;

endmodule

// File: rtl/regfile_dump_reader.sv
// Streams a contiguous (mod 32) range of a 32x64 register file out as ready/valid beats.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum beat at the end of each dump.
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_dump_reader_if.slave  bus
);

    dump_state_t           r_state;
    dump_state_t           w_next;
    logic [REG_ADDR_W-1:0] r_ptr;
    logic [REG_ADDR_W-1:0] r_sa;
    logic [REG_ADDR_W-1:0] r_sb;
    logic [CNT_W-1:0]      r_rem;
    logic [1:0]            w_fill_n;
    logic [1:0]            w_buf_fill;
    logic                  w_beat;
    logic                  w_pop;
    logic                  w_buf_last;
    logic [REG_DATA_W-1:0] w_head_data;
    logic [REG_ADDR_W-1:0] w_head_index;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [REG_DATA_W-1:0] r_csum;
`endif

    assign w_fill_n   = (r_rem >= 6'd2) ? 2'd2 : r_rem[1:0];
    assign w_beat     = bus.out_valid && bus.out_ready;
    assign w_pop      = (r_state == EMIT) && w_beat;
    assign w_buf_last = (w_buf_fill == 2'd1);
    assign bus.SA     = r_sa;
    assign bus.SB     = r_sb;

    regfile_dump_buf u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (r_state == READ),
        .i_load_n     (w_fill_n),
        .i_data0      (bus.A),
        .i_data1      (bus.B),
        .i_idx0       (r_sa),
        .i_idx1       (r_sb),
        .i_pop        (w_pop),
        .o_head_data  (w_head_data),
        .o_head_index (w_head_index),
        .o_fill       (w_buf_fill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = w_head_data;
        bus.out_index = w_head_index;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = READ;
                end
            end
            READ: begin
                bus.busy = 1'b1;
                w_next   = EMIT;
            end
            EMIT: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
`ifndef REGFILE_DUMP_CHECKSUM_EN
                bus.out_last  = w_buf_last && (r_rem == '0);
`endif
                if (w_pop && w_buf_last) begin
                    if (r_rem != '0) begin
                        w_next = READ;
                    end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        w_next = CSUM;
`else
                        w_next = DONE;
`endif
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            CSUM: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_last  = 1'b1;
                bus.out_data  = r_csum;
                bus.out_index = '0;
                if (w_beat) begin
                    w_next = DONE;
                end
            end
`endif
            DONE: begin
                bus.done = 1'b1;
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Read selects are only reloaded on entry to READ so they hold steady everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_rem  <= '0;
            r_sa   <= '0;
            r_sb   <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_csum <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_ptr  <= bus.first_reg;
                        r_rem  <= (bus.count == '0) ? 6'd32 : bus.count;
                        r_sa   <= bus.first_reg;
                        r_sb   <= bus.first_reg + 5'd1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        r_csum <= '0;
`endif
                    end
                end
                READ: begin
                    r_ptr <= r_ptr + 5'd2;
                    r_rem <= r_rem - {4'd0, w_fill_n};
                end
                EMIT: begin
                    if (w_pop) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        r_csum <= r_csum ^ w_head_data;
`endif
                        if (w_buf_last && (r_rem != '0)) begin
                            r_sa <= r_ptr;
                            r_sb <= r_ptr + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader against a 32x64 register file preloaded with 64'h1000+i.
// Follows the checksum beat as well when REGFILE_DUMP_CHECKSUM_EN is defined.
module tb_regfile_dump_reader;
    import regfile_pkg::*;

    typedef struct {
        logic [4:0] first;
        logic [5:0] cnt;
        int         nBeats;
        int         stallBeat;
        int         stallCycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] regs [32];
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs [7];

    always #5 clk = ~clk;

    regfile_dump_reader_if bus ();

    assign bus.A = regs[bus.SA];
    assign bus.B = regs[bus.SB];

    regfile_dump_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one dump; a stray start is pulsed mid-dump and during DONE, both must be ignored.
    task automatic applyStimulus(input logic [4:0] first, input logic [5:0] cnt, input int nBeats,
                                 input int stallBeat, input int stallCycles);
        int          k;
        int          cycles;
        int          stallLeft;
        int          totalBeats;
        bit          busyOk;
        bit          stallOk;
        bit          stalling;
        bit          lastExp;
        logic [4:0]  expIdx;
        logic [63:0] expData;
        logic [63:0] csum;
        logic [63:0] holdData;
        logic [4:0]  holdIdx;
        logic        holdLast;

        @(negedge clk);
        bus.start     = 1'b1;
        bus.first_reg = first;
        bus.count     = cnt;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("readBusy", bus.busy, 1);
        checkOutput("readValid", bus.out_valid, 0);
        checkOutput("readSA", bus.SA, first);
        checkOutput("readSB", bus.SB, 5'(first + 5'd1));
        @(negedge clk);
        checkOutput("firstValidLatency", bus.out_valid, 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
        totalBeats = nBeats + 1;
`else
        totalBeats = nBeats;
`endif
        k         = 0;
        cycles    = 0;
        stallLeft = stallCycles;
        busyOk    = 1'b1;
        stallOk   = 1'b1;
        csum      = '0;
        holdData  = '0;
        holdIdx   = '0;
        holdLast  = 1'b0;
        while (k < totalBeats && cycles < 400) begin
            if (cycles == 1) begin
                bus.start     = 1'b1;
                bus.first_reg = 5'd7;
                bus.count     = 6'd9;
            end else begin
                bus.start = 1'b0;
            end
            stalling      = (k == stallBeat) && (stallLeft > 0) && (bus.out_valid == 1'b1);
            bus.out_ready = !stalling;
            if (bus.busy !== 1'b1) busyOk = 1'b0;
            if (stalling) begin
                if (stallLeft == stallCycles) begin
                    holdData = bus.out_data;
                    holdIdx  = bus.out_index;
                    holdLast = bus.out_last;
                end else if (bus.out_data !== holdData || bus.out_index !== holdIdx ||
                             bus.out_last !== holdLast || bus.out_valid !== 1'b1) begin
                    stallOk = 1'b0;
                end
                stallLeft--;
            end else if (bus.out_valid === 1'b1) begin
                if (k < nBeats) begin
                    expIdx  = 5'((first + k) % 32);
                    expData = regs[expIdx];
                    csum    = csum ^ expData;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    lastExp = 1'b0;
`else
                    lastExp = (k == nBeats - 1);
`endif
                    checkOutput($sformatf("beat%0d_index", k), bus.out_index, expIdx);
                    checkOutput($sformatf("beat%0d_data", k), bus.out_data, expData);
                    checkOutput($sformatf("beat%0d_last", k), bus.out_last, lastExp);
                end else begin
                    checkOutput("csumData", bus.out_data, csum);
                    checkOutput("csumIndex", bus.out_index, 0);
                    checkOutput("csumLast", bus.out_last, 1);
                end
                k++;
            end
            cycles++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkOutput("beatCount", k, totalBeats);
        checkOutput("busyThroughout", busyOk, 1);
        if (stallCycles > 0) checkOutput("stallStable", stallOk, 1);
        checkOutput("doneAfterLast", bus.done, 1);
        checkOutput("busyInDone", bus.busy, 0);
        checkOutput("validInDone", bus.out_valid, 0);
        bus.start     = 1'b1;
        bus.first_reg = 5'd0;
        bus.count     = 6'd1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("donePulseEnds", bus.done, 0);
        checkOutput("startInDoneIgnored", bus.busy, 0);
    endtask

    initial begin
        bit         quietOk;
        int         seen;
        int         cycles;

        for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
        bus.start     = 1'b0;
        bus.first_reg = '0;
        bus.count     = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{5'd0,  6'd4, 4,  -1, 0};
        vecs[1] = '{5'd30, 6'd3, 3,  -1, 0};
        vecs[2] = '{5'd5,  6'd0, 32, -1, 0};
        vecs[3] = '{5'd0,  6'd6, 6,  1,  5};
        vecs[4] = '{5'd31, 6'd2, 2,  -1, 0};
        vecs[5] = '{5'd10, 6'd1, 1,  -1, 0};
        vecs[6] = '{5'd3,  6'd5, 5,  3,  2};

        #1;
        checkOutput("resetValid", bus.out_valid, 0);
        checkOutput("resetBusy", bus.busy, 0);
        checkOutput("resetDone", bus.done, 0);
        checkOutput("resetData", bus.out_data, 0);
        checkOutput("resetSA", bus.SA, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].first, vecs[i].cnt, vecs[i].nBeats, vecs[i].stallBeat, vecs[i].stallCycles);
        end

        // Abandon a dump after two beats with an asynchronous reset.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.first_reg = 5'd0;
        bus.count     = 6'd8;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen   = 0;
        cycles = 0;
        while (seen < 2 && cycles < 50) begin
            if (bus.out_valid === 1'b1) seen++;
            cycles++;
            @(negedge clk);
        end
        checkOutput("preResetBeats", seen, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetValid", bus.out_valid, 0);
        checkOutput("midResetData", bus.out_data, 0);
        checkOutput("midResetIndex", bus.out_index, 0);
        checkOutput("midResetLast", bus.out_last, 0);
        checkOutput("midResetBusy", bus.busy, 0);
        checkOutput("midResetDone", bus.done, 0);
        checkOutput("midResetSA", bus.SA, 0);
        checkOutput("midResetSB", bus.SB, 0);
        quietOk = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) quietOk = 1'b0;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) quietOk = 1'b0;
        end
        checkOutput("noBeatsAfterReset", quietOk, 1);
        applyStimulus(5'd0, 6'd1, 1, -1, 0);

`ifdef REGFILE_DUMP_CHECKSUM_EN
        regs[0] = 64'h1;
        regs[1] = 64'h3;
        applyStimulus(5'd0, 6'd2, 2, -1, 0);
        regs[0] = 64'h1000;
        regs[1] = 64'h1001;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
